myproject_div_seq_22s_11s: RTL and testbench

MYPROJECT_DIV_SEQ_22S_11S -- requirements
Module: myproject_div_seq_22s_11s

---
 rtl/myproject_div_seq_22s_11s.sv | 168 ++++++++++++++++
 tb/tb_myproject_div_seq_22s_11s.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/myproject_div_seq_22s_11s.sv
// Sequential signed divider: DIVIDEND_WIDTH-bit dividend by DIVISOR_WIDTH-bit
// divisor, one restoring shift-subtract step per cycle on magnitudes.
// Quotient rounds toward zero; the remainder takes the dividend's sign.
// Optional build macro MYPROJECT_DIV_SAT_EN: saturate an overflowing quotient
// instead of returning its low DIVISOR_WIDTH bits.
// Handshake: in IDLE, ap_start=1 captures din0/din1 in the same cycle and
// ap_ready pulses there; ap_done pulses for the single DONE cycle, during
// which quot/rem/ovf/div_zero are already valid and then held until the next
// DONE. The FSM state is visible on the internal signal 'state'.
module myproject_div_seq_22s_11s #(
  parameter int DIVIDEND_WIDTH = 22,
  parameter int DIVISOR_WIDTH  = 11
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      ap_start,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      ap_idle,
  output logic                      ap_ready,
  output logic                      ap_done,
  output logic [DIVISOR_WIDTH-1:0]  quot,
  output logic [DIVISOR_WIDTH-1:0]  rem,
  output logic                      ovf,
  output logic                      div_zero
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int DV = DIVISOR_WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);
  localparam logic [DV-1:0] QMAX = {1'b0, {(DV-1){1'b1}}};
  localparam logic [DV-1:0] QMIN = {1'b1, {(DV-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  // Dividend magnitude shifts out of the top while quotient bits enter at
  // the bottom; after DW steps the register holds the quotient magnitude.
  logic [DW-1:0] dvd_sh;
  logic [DV:0]   dsr_mag;
  logic [DV-1:0] rem_acc;
  logic          neg_dvd;
  logic          neg_dsr;

  logic [DW:0]   din0_ext;
  logic [DV:0]   din1_ext;
  logic [DW-1:0] dvd_load;
  logic [DV:0]   dsr_load;
  logic          dsr_zero;
  logic          last_step;
  logic [DV:0]   rem_sh;
  logic          sub_ok;
  logic [DV-1:0] rem_step;
  logic [DW-1:0] quo_step;
  logic [DW:0]   q_true;
  logic          ovf_calc;
  logic [DV-1:0] quot_calc;
  logic [DV-1:0] rem_calc;

  // Operand magnitudes, one bit wider so the most negative value does not wrap.
  always_comb begin
    din0_ext = {din0[DW-1], din0};
    din1_ext = {din1[DV-1], din1};
    dvd_load = DW'(din0[DW-1] ? -din0_ext : din0_ext);
    dsr_load = din1[DV-1] ? -din1_ext : din1_ext;
    dsr_zero = (din1 == '0);
  end

  // One restoring step plus the signed result it would produce if it is the last.
  always_comb begin
    last_step = (cnt == LAST_STEP);
    rem_sh    = {rem_acc, dvd_sh[DW-1]};
    sub_ok    = (rem_sh >= dsr_mag);
    rem_step  = sub_ok ? DV'(rem_sh - dsr_mag) : rem_sh[DV-1:0];
    quo_step  = {dvd_sh[DW-2:0], sub_ok};
    q_true    = (neg_dvd ^ neg_dsr) ? -{1'b0, quo_step} : {1'b0, quo_step};
    // In range exactly when the bits above the result sign are a sign extension.
    ovf_calc  = !((&q_true[DW:DV-1]) || (~|q_true[DW:DV-1]));
`ifdef MYPROJECT_DIV_SAT_EN
    quot_calc = ovf_calc ? (q_true[DW] ? QMIN : QMAX) : q_true[DV-1:0];
`else
    quot_calc = q_true[DV-1:0];
`endif
    rem_calc  = neg_dvd ? -rem_step : rem_step;
  end

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs; reset masks same-cycle pulses.
  always_comb begin
    state_nxt = state;
    ap_idle   = 1'b0;
    ap_ready  = 1'b0;
    ap_done   = 1'b0;
    case (state)
      IDLE: begin
        ap_idle  = 1'b1;
        ap_ready = ap_start && !ap_rst;
        if (ap_start) state_nxt = dsr_zero ? DONE : CALC;
      end
      CALC: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        ap_done   = !ap_rst;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture in IDLE, step in CALC, publish results on DONE entry.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt      <= '0;
      dvd_sh   <= '0;
      dsr_mag  <= '0;
      rem_acc  <= '0;
      neg_dvd  <= 1'b0;
      neg_dsr  <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      ovf      <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            cnt     <= '0;
            dvd_sh  <= dvd_load;
            dsr_mag <= dsr_load;
            rem_acc <= '0;
            neg_dvd <= din0[DW-1];
            neg_dsr <= din1[DV-1];
            if (dsr_zero) begin
              quot     <= din0[DW-1] ? QMIN : QMAX;
              rem      <= '0;
              ovf      <= 1'b0;
              div_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          dvd_sh  <= quo_step;
          rem_acc <= rem_step;
          if (last_step) begin
            cnt      <= '0;
            quot     <= quot_calc;
            rem      <= rem_calc;
            ovf      <= ovf_calc;
            div_zero <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_div_seq_22s_11s.sv
// Testbench for myproject_div_seq_22s_11s: directed corner cases, reset abort,
// back-to-back starts and randomized operands against an integer-division model.
module tb_myproject_div_seq_22s_11s;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic [21:0] din0;
  logic [10:0] din1;
  logic        ap_idle;
  logic        ap_ready;
  logic        ap_done;
  logic [10:0] quot;
  logic [10:0] rem;
  logic        ovf;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;

  // Expected held outputs, updated by the bench whenever a division completes.
  logic [10:0] h_quot;
  logic [10:0] h_rem;
  logic        h_ovf;
  logic        h_dz;

  myproject_div_seq_22s_11s dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .ap_start (ap_start),
    .din0     (din0),
    .din1     (din1),
    .ap_idle  (ap_idle),
    .ap_ready (ap_ready),
    .ap_done  (ap_done),
    .quot     (quot),
    .rem      (rem),
    .ovf      (ovf),
    .div_zero (div_zero)
  );

  // Clock.
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain truncating integer division.
  task automatic model(input logic signed [21:0] a, input logic signed [10:0] b,
                       output int lat, output logic [10:0] q, output logic [10:0] r,
                       output logic o, output logic z);
    longint la;
    longint lb;
    longint tq;
    longint tr;
    la = a;
    lb = b;
    if (lb == 0) begin
      lat = 1;
      z   = 1'b1;
      o   = 1'b0;
      r   = 11'h000;
      q   = (la >= 0) ? 11'h3FF : 11'h400;
    end else begin
      lat = 23;
      z   = 1'b0;
      tq  = la / lb;
      tr  = la % lb;
      o   = (tq > 1023) || (tq < -1024);
`ifdef MYPROJECT_DIV_SAT_EN
      if (o) q = (tq > 0) ? 11'h3FF : 11'h400;
      else   q = tq[10:0];
`else
      q = tq[10:0];
`endif
      r = tr[10:0];
    end
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    din0     = '0;
    din1     = '0;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
  endtask

  // One full division from an idle DUT, checking handshake, latency and results.
  task automatic do_div(input logic signed [21:0] a, input logic signed [10:0] b, input string tag);
    int          lat;
    int          done_cyc;
    logic [10:0] eq;
    logic [10:0] er;
    logic        eo;
    logic        ez;
    model(a, b, lat, eq, er, eo, ez);
    @(negedge ap_clk);
    din0     = a;
    din1     = b;
    ap_start = 1'b1;
    #1;
    check({tag, ".ready"}, ap_ready, 1);
    done_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge ap_clk);
      ap_start = 1'b0;
      #1;
      if (ap_done) begin
        done_cyc = c;
        break;
      end
    end
    check({tag, ".latency"}, done_cyc, lat);
    check({tag, ".quot"}, quot, eq);
    check({tag, ".rem"}, rem, er);
    check({tag, ".ovf"}, ovf, eo);
    check({tag, ".div_zero"}, div_zero, ez);
    h_quot = eq;
    h_rem  = er;
    h_ovf  = eo;
    h_dz   = ez;
    @(negedge ap_clk);
    #1;
    check({tag, ".done_once"}, ap_done, 0);
    check({tag, ".idle_after"}, ap_idle, 1);
    check({tag, ".quot_hold"}, quot, h_quot);
    check({tag, ".rem_hold"}, rem, h_rem);
  endtask

  initial begin
    int          ndone;
    int          done_cyc;
    int          lat;
    int          v;
    logic [10:0] eq;
    logic [10:0] er;
    logic        eo;
    logic        ez;
    logic [21:0] ra;
    logic [10:0] rb;

    // Reset state.
    do_reset();
    check("rst.idle", ap_idle, 1);
    check("rst.ready", ap_ready, 0);
    check("rst.done", ap_done, 0);
    check("rst.quot", quot, 0);
    check("rst.rem", rem, 0);
    check("rst.ovf", ovf, 0);
    check("rst.div_zero", div_zero, 0);
    h_quot = '0; h_rem = '0; h_ovf = 1'b0; h_dz = 1'b0;

    // Directed cases, including overflow and divide-by-zero corners.
    do_div(22'sd1000, 11'sd7, "d1000_7");
    do_div(-22'sd1000, 11'sd7, "dm1000_7");
    do_div(22'sd1000, -11'sd7, "d1000_m7");
    do_div(22'sd2097151, 11'sd1, "dmax_1");
    do_div(-22'sd1024, -11'sd1, "dm1024_m1");
    do_div(22'sd5, 11'sd0, "d5_0");
    do_div(-22'sd5, 11'sd0, "dm5_0");
    do_div(22'sh200000, 11'sd1, "dmin_1");
    do_div(22'sh200000, -11'sd1, "dmin_m1");
    do_div(22'sh200000, 11'sh400, "dmin_min");
    do_div(22'sd1023, -11'sd1, "d1023_m1");
    do_div(-22'sd3, 11'sd7, "dm3_7");

    // Reset in the middle of a division aborts it.
    @(negedge ap_clk);
    din0 = 22'sd1000; din1 = 11'sd7; ap_start = 1'b1;
    #1;
    check("abort.ready", ap_ready, 1);
    ndone = 0;
    for (int c = 1; c < 10; c++) begin
      @(negedge ap_clk);
      ap_start = 1'b0;
      #1;
      if (ap_done) ndone++;
    end
    @(negedge ap_clk);
    ap_rst = 1'b1;
    #1;
    if (ap_done) ndone++;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (ap_done) ndone++;
      @(negedge ap_clk);
    end
    #1;
    check("abort.no_done", ndone, 0);
    check("abort.idle", ap_idle, 1);
    check("abort.quot", quot, 0);
    check("abort.rem", rem, 0);
    check("abort.ovf", ovf, 0);
    check("abort.div_zero", div_zero, 0);
    h_quot = '0; h_rem = '0; h_ovf = 1'b0; h_dz = 1'b0;
    do_div(22'sd100, 11'sd9, "d100_9");

    // ap_start held high for 60 cycles; operands change mid-division.
    @(negedge ap_clk);
    din0 = 22'sd1000; din1 = 11'sd7; ap_start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge ap_clk);
      if (c == 5) begin
        din0 = 22'sd100; din1 = 11'sd9;
      end
      #1;
      if (c % 24 == 23) begin
        if (c < 24) model(22'sd1000, 11'sd7, lat, eq, er, eo, ez);
        else        model(22'sd100, 11'sd9, lat, eq, er, eo, ez);
        h_quot = eq; h_rem = er; h_ovf = eo; h_dz = ez;
      end
      check("b2b.ready", ap_ready, (c % 24 == 0) ? 1 : 0);
      check("b2b.done", ap_done, (c % 24 == 23) ? 1 : 0);
      check("b2b.quot", quot, h_quot);
      check("b2b.rem", rem, h_rem);
    end
    done_cyc = -1;
    for (int c = 60; c < 90; c++) begin
      @(negedge ap_clk);
      ap_start = 1'b0;
      #1;
      if (ap_done) begin
        done_cyc = c;
        break;
      end
    end
    check("b2b.last_done", done_cyc, 71);
    check("b2b.last_quot", quot, 11);
    check("b2b.last_rem", rem, 1);
    @(negedge ap_clk);

    // Randomized operands.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        v  = int'($urandom_range(0, 40000)) - 20000;
        ra = 22'(v);
      end else begin
        ra = 22'($urandom);
      end
      rb = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 9) == 0) rb = '0;
      do_div(ra, rb, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
